// File: rtl/udma_pkg.sv
// Shared uDMA event definitions: default event-lines-per-peripheral, the event
// ID type and the helper that maps (peripheral, event) onto a flat line ID.
package udma_pkg;

  localparam int EVT_PER_PERIPH = 4;
  localparam int UDMA_ID_WIDTH  = 8;

  typedef logic [UDMA_ID_WIDTH-1:0] udma_evt_id_t;

  function automatic udma_evt_id_t evt_id(input int unsigned periph, input int unsigned evt);
    return udma_evt_id_t'(periph * EVT_PER_PERIPH + evt);
  endfunction

endpackage

// File: rtl/udma_rr_arb.sv
// Round-robin arbiter: combinational pick starting at a registered pointer.
// The pointer moves past the winner only when the grant is actually taken.
module udma_rr_arb #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_o
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             take;

  assign any_o = |req_i;
  assign take  = en_i && any_o;

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    // NOTE: every variable gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    found     = 1'b0;
    gnt_idx_o = '0;
    cand      = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[cand]) begin
        found     = 1'b1;
        gnt_idx_o = cand;
      end
      cand = (cand == LAST) ? '0 : cand + 1'b1;
    end
  end

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    if (take) begin
      gnt_o[gnt_idx_o] = 1'b1;
      ptr_d            = (gnt_idx_o == LAST) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/udma_evt_serializer.sv
// Event concentrator: per-line saturating pending counters drained one ID per
// cycle through a registered valid/ready output, with round-robin fairness.
module udma_evt_serializer
  import udma_pkg::*;
#(
  parameter int N_PERIPHS = 32,
  parameter int N_EVT_PER = EVT_PER_PERIPH,
  parameter int CNT_WIDTH = 2,
  parameter int ID_WIDTH  = 8
) (
  input  logic                                sys_clk_i,
  input  logic                                sys_rst_i,
  input  logic [N_PERIPHS-1:0][N_EVT_PER-1:0] events_i,
  input  logic [N_PERIPHS*N_EVT_PER-1:0]      mask_i,
  input  logic                                clr_i,
  output logic                                evt_valid_o,
  output logic [ID_WIDTH-1:0]                 evt_data_o,
  input  logic                                evt_ready_i,
  output logic                                overflow_o,
  output logic [ID_WIDTH-1:0]                 overflow_id_o,
  output logic                                busy_o
);

  localparam int N_LINES = N_PERIPHS * N_EVT_PER;
  localparam int LIDX_W  = (N_LINES > 1) ? $clog2(N_LINES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  if (N_PERIPHS < 1 || N_PERIPHS > 64) begin : g_periph_check
    $error("udma_evt_serializer: N_PERIPHS must be in 1..64");
  end
  if (N_LINES > (2 ** ID_WIDTH)) begin : g_id_check
    $error("udma_evt_serializer: ID_WIDTH too narrow for N_PERIPHS*N_EVT_PER lines");
  end

  logic [N_LINES-1:0] ev_flat, inc, req, gnt, drop;
  logic [LIDX_W-1:0]  gnt_idx;
  logic               any_req, load, grant_en;

  logic                valid_q, valid_d;
  logic [ID_WIDTH-1:0] data_q, data_d;
  logic                ovf_q, ovf_d;
  logic [ID_WIDTH-1:0] ovf_id_q, ovf_id_d;

  assign ev_flat  = events_i;
  assign inc      = ev_flat & mask_i;
  assign load     = !valid_q || evt_ready_i;
  // A clear empties every counter this cycle, so nothing may be granted.
  assign grant_en = load && !clr_i;

  udma_rr_arb #(.N(N_LINES)) u_arb (
    .clk_i     (sys_clk_i),
    .rst_i     (sys_rst_i),
    .req_i     (req),
    .en_i      (grant_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (any_req)
  );

  for (genvar i = 0; i < N_LINES; i++) begin : g_line
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
        cnt_d = '0;
      end else if (inc[i] && !gnt[i]) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else if (gnt[i] && !inc[i]) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    assign drop[i] = !clr_i && inc[i] && !gnt[i] && (cnt_q == CNT_MAX);
    assign req[i]  = |cnt_q;

    always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) cnt_q <= '0;
      else           cnt_q <= cnt_d;
    end
  end

  always_comb begin
    logic              found;
    logic [LIDX_W-1:0] k;
    found    = 1'b0;
    k        = '0;
    ovf_d    = |drop;
    ovf_id_d = '0;
    for (int i = 0; i < N_LINES; i++) begin
      if (!found && drop[k]) begin
        found    = 1'b1;
        ovf_id_d = ID_WIDTH'(k);
      end
      k = k + 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = grant_en && any_req;
      if (grant_en && any_req) data_d = ID_WIDTH'(gnt_idx);
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      ovf_id_q <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      ovf_id_q <= ovf_id_d;
    end
  end

  assign evt_valid_o   = valid_q;
  assign evt_data_o    = data_q;
  assign overflow_o    = ovf_q;
  assign overflow_id_o = ovf_id_q;
  assign busy_o        = (|req) || valid_q;

endmodule

// File: tb/tb_udma_evt_serializer.sv
// Directed bench for udma_evt_serializer: a vector table for latency and
// round-robin order, plus hand-written multi-cycle corner-case sequences.
module tb_udma_evt_serializer;
  import udma_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst, clr, ready;
  logic [127:0]         ev_flat, mask;
  logic [31:0][3:0]     events;
  logic                 valid, ovf, busy;
  logic [7:0]           data, ovf_id;

  int n_checks = 0;
  int n_errors = 0;

  assign events = ev_flat;
  always #5 clk = ~clk;

  udma_evt_serializer dut (
    .sys_clk_i     (clk),
    .sys_rst_i     (rst),
    .events_i      (events),
    .mask_i        (mask),
    .clr_i         (clr),
    .evt_valid_o   (valid),
    .evt_data_o    (data),
    .evt_ready_i   (ready),
    .overflow_o    (ovf),
    .overflow_id_o (ovf_id),
    .busy_o        (busy)
  );

  typedef struct {
    logic       rst;
    int         id0, id1, id2;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_busy;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input int a, input int b, input int c,
                              input logic v, input int d, input logic bz);
    vec_t t;
    t.rst = r; t.id0 = a; t.id1 = b; t.id2 = c;
    t.e_valid = v; t.e_data = d[7:0]; t.e_busy = bz;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Data is only compared while valid is expected high.
  task automatic exp_out(input string tag, input logic v, input logic [7:0] d, input logic b,
                         input logic o, input logic [7:0] oid);
    check({tag, ".valid"}, 32'(valid), 32'(v));
    if (v) check({tag, ".data"}, 32'(data), 32'(d));
    check({tag, ".ovf"}, 32'(ovf), 32'(o));
    check({tag, ".ovf_id"}, 32'(ovf_id), 32'(oid));
    check({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  task automatic pulse(input int id);
    if (id >= 0) ev_flat[id[6:0]] = 1'b1;
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    ev_flat = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clr = 1'b0; ready = 1'b1; ev_flat = '0; mask = '1;
    @(negedge clk);
    tick();
    rst = 1'b0;

    // Latency of a single pulse, then round-robin order with pointer wrap.
    vecs[0]  = mk(1, -1, -1, -1, 0, 0, 0);
    vecs[1]  = mk(0, int'(evt_id(3, 1)), -1, -1, 0, 0, 1);
    vecs[2]  = mk(0, -1, -1, -1, 1, 13, 1);
    vecs[3]  = mk(0, -1, -1, -1, 0, 0, 0);
    vecs[4]  = mk(1, -1, -1, -1, 0, 0, 0);
    vecs[5]  = mk(0, 0, 5, 127, 0, 0, 1);
    vecs[6]  = mk(0, -1, -1, -1, 1, 0, 1);
    vecs[7]  = mk(0, -1, -1, -1, 1, 5, 1);
    vecs[8]  = mk(0, -1, -1, -1, 1, 127, 1);
    vecs[9]  = mk(0, 0, 5, -1, 0, 0, 1);
    vecs[10] = mk(0, -1, -1, -1, 1, 0, 1);
    vecs[11] = mk(0, -1, -1, -1, 1, 5, 1);
    vecs[12] = mk(0, -1, -1, -1, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst;
      pulse(vecs[i].id0); pulse(vecs[i].id1); pulse(vecs[i].id2);
      tick();
      rst = 1'b0;
      exp_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data, vecs[i].e_busy, 1'b0, 8'd0);
    end

    // Backpressure: held id 7, three more queue, the fourth is dropped.
    do_reset(); ready = 1'b0;
    pulse(7); tick(); exp_out("bp.cap", 0, 0, 1, 0, 0);
    tick();           exp_out("bp.held", 1, 7, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      pulse(7); tick(); exp_out($sformatf("bp.q%0d", i), 1, 7, 1, 0, 0);
    end
    pulse(7); tick(); exp_out("bp.drop", 1, 7, 1, 1, 7);
    tick();           exp_out("bp.ovf_clr", 1, 7, 1, 0, 0);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); exp_out($sformatf("bp.drain%0d", i), 1, 7, 1, 0, 0);
    end
    tick(); exp_out("bp.done", 0, 0, 0, 0, 0);

    // Increment and grant on a saturated line in the same cycle: no drop.
    do_reset(); ready = 1'b0;
    pulse(7); tick(); tick();
    for (int i = 0; i < 3; i++) begin pulse(7); tick(); end
    ready = 1'b1; pulse(7); tick(); exp_out("sat.incdec", 1, 7, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); exp_out($sformatf("sat.drain%0d", i), 1, 7, 1, 0, 0);
    end
    tick(); exp_out("sat.done", 0, 0, 0, 0, 0);

    // Overflow reports the lowest dropped line.
    do_reset(); ready = 1'b0;
    pulse(40); pulse(100); tick(); exp_out("low.c1", 0, 0, 1, 0, 0);
    pulse(40); pulse(100); tick(); exp_out("low.c2", 1, 40, 1, 0, 0);
    pulse(40); pulse(100); tick(); exp_out("low.c3", 1, 40, 1, 0, 0);
    pulse(40); pulse(100); tick(); exp_out("low.c4", 1, 40, 1, 1, 100);
    pulse(40); pulse(100); tick(); exp_out("low.c5", 1, 40, 1, 1, 40);

    // Masking gates capture but not draining.
    do_reset(); ready = 1'b1; mask[20] = 1'b0;
    pulse(20);
    for (int i = 0; i < 3; i++) begin
      tick(); exp_out($sformatf("mask.off%0d", i), 0, 0, 0, 0, 0);
    end
    mask = '1; ready = 1'b0;
    pulse(33); tick(); pulse(33); tick(); pulse(33); tick();
    exp_out("mask.pend", 1, 33, 1, 0, 0);
    mask[33] = 1'b0; ready = 1'b1;
    pulse(33); tick(); exp_out("mask.d0", 1, 33, 1, 0, 0);
    tick();           exp_out("mask.d1", 1, 33, 1, 0, 0);
    tick();           exp_out("mask.d2", 0, 0, 0, 0, 0);
    mask = '1;

    // Clear: held id 2 completes, pending id 9 and same-cycle pulse vanish.
    do_reset(); ready = 1'b0;
    pulse(2); pulse(9); tick(); exp_out("clr.cap", 0, 0, 1, 0, 0);
    tick(); exp_out("clr.held", 1, 2, 1, 0, 0);
    clr = 1'b1; pulse(9); tick(); clr = 1'b0;
    exp_out("clr.apply", 1, 2, 1, 0, 0);
    tick(); exp_out("clr.hold", 1, 2, 1, 0, 0);
    ready = 1'b1;
    tick(); exp_out("clr.hs", 0, 0, 0, 0, 0);
    tick(); exp_out("clr.none", 0, 0, 0, 0, 0);
    pulse(9); tick(); exp_out("clr.p9", 0, 0, 1, 0, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    exp_out("clr.noload", 0, 0, 0, 0, 0);
    tick(); exp_out("clr.after", 0, 0, 0, 0, 0);

    // Reset while an event is held drops it without a handshake.
    ready = 1'b0;
    pulse(13); tick(); tick(); exp_out("rst.held", 1, 13, 1, 0, 0);
    pulse(13); rst = 1'b1; tick(); rst = 1'b0;
    exp_out("rst.apply", 0, 0, 0, 0, 0);
    check("rst.data", 32'(data), 32'd0);
    tick(); exp_out("rst.after", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
